fft_frame_sched: RTL and testbench
==================================

Name: fft_frame_sched

Overview:
- Frame scheduler that shares one streaming FFT core between two sample FIFOs (source 0, source 1).
- Grants the FFT to one source per frame using round-robin, then issues FIFO reads for exactly FFT_LEN samples.
- Buffers read data in a 4-entry skid buffer and drives the FFT AXI-stream input with tvalid/tlast/tuser.
- Sits on clk_300m between the CDC FIFOs and the FFT/IFFT calibration core.

Parameters:
- FFT_LEN, 512, samples per frame; power of two, 8..4096.
- DATA_W, 48, sample width (packed I/Q).
- CNT_W, 13, width of the FIFO fill-level inputs.
- THRESH, 1100, minimum fill level for a source to request a frame; must be >= FFT_LEN.
- MAX_FRAMES, 0, frames to run before halting; 0 = unlimited.

Ports:
- clk_300m  in  1  clock.
- locrstn  in  1  reset, asynchronous, active-high.
- enable  in  1  start/continue scheduling.
- src0_count  in  CNT_W  source-0 FIFO fill level.
- src0_empty  in  1  source-0 FIFO empty.
- src0_rd_en  out  1  source-0 FIFO read enable.
- src0_dout  in  DATA_W  source-0 FIFO data.
- src0_valid  in  1  source-0 read data valid, one cycle after rd_en.
- src1_count, src1_empty, src1_rd_en, src1_dout, src1_valid: same as source 0, for source 1.
- fft_tready  in  1  FFT input ready.
- fft_tdata  out  DATA_W  FFT input data.
- fft_tvalid  out  1  FFT input valid.
- fft_tlast  out  1  last beat of frame.
- fft_tuser  out  1  source id of the current frame.
- frame_done  out  1  one-cycle pulse at frame end.
- frame_cnt  out  16  completed frames, saturating.
- busy  out  1  high in any state except IDLE.
- underrun_err  out  1  sticky underrun flag.
- stall_cycles  out  16  stall statistics; see Optional Feature.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - issue_cnt, beat_cnt and skid buffer cleared.
  - last_grant = 1, so source 0 wins the first arbitration.
- Reset asserted mid-frame: abort immediately and discard buffered data. No tlast is emitted.
- FSM states: IDLE, ARB, READ, DRAIN, DONE.
- IDLE -> ARB when enable=1.
- ARB:
  - req_n = (srcn_count >= THRESH).
  - Halt condition: MAX_FRAMES != 0 and frame_cnt == MAX_FRAMES. When halted, stay in ARB and issue no grant.
  - If both sources request, grant the source != last_grant. If only one requests, grant it.
  - On a grant: latch grant into fft_tuser, clear counters, go to READ.
  - If enable=0 and no grant is made, go to IDLE.
- READ:
  - srcG_rd_en = !srcG_empty && issue_cnt < FFT_LEN && (occ + inflight) < 3.
    - occ is skid buffer occupancy; inflight is rd_en registered one cycle.
    - The non-granted rd_en stays 0.
  - issue_cnt increments on each rd_en. Go to DRAIN when issue_cnt reaches FFT_LEN.
- Skid buffer:
  - Push srcG_dout when srcG_valid.
  - fft_tvalid = (occ != 0); fft_tdata = head entry; pop on tvalid & tready.
  - Latency: rd_en in cycle t gives fft_tvalid in cycle t+2.
  - With fft_tready held high, throughput is 1 beat/cycle.
  - The gating rule guarantees occ <= 4. Overflow is impossible, and the bench asserts it.
- beat_cnt counts output handshakes. fft_tlast = fft_tvalid && beat_cnt == FFT_LEN-1.
- DRAIN: go to DONE on the handshake of the tlast beat.
- DONE (1 cycle):
  - frame_done=1; frame_cnt++ (saturates at 0xFFFF); last_grant = fft_tuser.
  - Go to ARB if enable, else IDLE.
- enable dropped mid-frame: the current frame completes fully; enable is sampled only in IDLE, ARB and DONE.
- Underrun: underrun_err sets when in READ, issue_cnt < FFT_LEN and srcG_empty=1. The frame then stalls until data arrives. The flag is cleared only by locrstn.
- fft_tready low: reads throttle through the occ+inflight rule. No beat is dropped or duplicated.
- Counters (width clog2(FFT_LEN)+1) never wrap within a frame.

Optional Feature:
- Macro: FFT_SCHED_STALL_CNT_EN.
- Defined: stall_cycles is a 16-bit saturating counter. It increments every cycle in READ where issue_cnt < FFT_LEN and either srcG_empty=1 or fft_tready=0. Cleared by locrstn only.
- Undefined: stall_cycles is tied to 0 and no counter logic is built.

Test Plan:
- Only src0_count=1200, fft_tready=1, FIFO model always non-empty -> 512 beats, fft_tuser=0, tlast on beat 511 only, frame_done 1 cycle after tlast handshake, frame_cnt=1.
- Both sources at 1200, enable held -> grants alternate 0,1,0,1 over 4 frames; frame_cnt=4; first tvalid 2 cycles after first rd_en.
- fft_tready toggled 1/0 every 3 cycles during a frame -> exactly 512 beats in order (compare against a sequence-number pattern), occ never > 4.
- src0 FIFO goes empty after 300 reads, refilled 50 cycles later -> underrun_err=1, frame still 512 beats, stall_cycles >= 50 with macro, 0 without.
- MAX_FRAMES=2, both sources requesting -> exactly 2 frame_done pulses, then FSM holds in ARB with busy=1 and rd_en=0.
- locrstn pulsed at beat 200 -> all outputs 0 next cycle; after release with enable=1, source 0 granted and a full 512-beat frame with tlast follows.

Source files
------------

// File: rtl/fft_frame_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_frame_sched: round-robin frame scheduler sharing one streaming FFT
// between two sample FIFOs. Optional stall counter: FFT_SCHED_STALL_CNT_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module fft_frame_sched #(
  parameter int FFT_LEN    = 512,
  parameter int DATA_W     = 48,
  parameter int CNT_W      = 13,
  parameter int THRESH     = 1100,
  parameter int MAX_FRAMES = 0
) (
  input  logic              clk_300m,
  input  logic              locrstn,
  input  logic              enable,
  input  logic [CNT_W-1:0]  src0_count,
  input  logic              src0_empty,
  output logic              src0_rd_en,
  input  logic [DATA_W-1:0] src0_dout,
  input  logic              src0_valid,
  input  logic [CNT_W-1:0]  src1_count,
  input  logic              src1_empty,
  output logic              src1_rd_en,
  input  logic [DATA_W-1:0] src1_dout,
  input  logic              src1_valid,
  input  logic              fft_tready,
  output logic [DATA_W-1:0] fft_tdata,
  output logic              fft_tvalid,
  output logic              fft_tlast,
  output logic              fft_tuser,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic              busy,
  output logic              underrun_err,
  output logic [15:0]       stall_cycles
);
  localparam int CW = $clog2(FFT_LEN) + 1;

  typedef enum logic [2:0] {IDLE = 3'd0, ARB = 3'd1, READ = 3'd2, DRAIN = 3'd3, DONE = 3'd4} state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [CW-1:0]     issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]     beat_cnt_q, beat_cnt_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] skid_q [4];
  logic [DATA_W-1:0] skid_d [4];
  logic [1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]        occ_q, occ_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              underrun_q, underrun_d;

  logic              req0, req1, halted, g_empty, g_valid, rd_en, push, pop, issue_left;
  logic [DATA_W-1:0] g_dout;

  assign req0       = src0_count >= CNT_W'(THRESH);
  assign req1       = src1_count >= CNT_W'(THRESH);
  assign halted     = (MAX_FRAMES != 0) && (frame_cnt_q == 16'(MAX_FRAMES));
  assign g_empty    = grant_q ? src1_empty : src0_empty;
  assign g_valid    = grant_q ? src1_valid : src0_valid;
  assign g_dout     = grant_q ? src1_dout  : src0_dout;
  assign issue_left = issue_cnt_q < CW'(FFT_LEN);
  // Counting in-flight reads keeps the skid buffer from ever needing more than 3 slots.
  assign rd_en      = (state_q == READ) && !g_empty && issue_left &&
                      ((occ_q + {2'b00, inflight_q}) < 3'd3);
  assign push       = g_valid && ((state_q == READ) || (state_q == DRAIN));
  assign pop        = (occ_q != 3'd0) && fft_tready;

  assign src0_rd_en   = rd_en && !grant_q;
  assign src1_rd_en   = rd_en && grant_q;
  assign fft_tvalid   = occ_q != 3'd0;
  assign fft_tdata    = skid_q[rd_ptr_q];
  assign fft_tlast    = fft_tvalid && (beat_cnt_q == CW'(FFT_LEN - 1));
  assign fft_tuser    = grant_q;
  assign frame_done   = state_q == DONE;
  assign frame_cnt    = frame_cnt_q;
  assign busy         = state_q != IDLE;
  assign underrun_err = underrun_q;

  always_comb begin
    skid_d   = skid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      skid_d[wr_ptr_q] = g_dout;
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    occ_d = occ_q + {2'b00, push} - {2'b00, pop};
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    issue_cnt_d  = issue_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    underrun_d   = underrun_q;
    inflight_d   = rd_en;
    if (rd_en) issue_cnt_d = issue_cnt_q + CW'(1);
    if (pop)   beat_cnt_d  = beat_cnt_q + CW'(1);
    if ((state_q == READ) && issue_left && g_empty) underrun_d = 1'b1;
    unique case (state_q)
      IDLE: if (enable) state_d = ARB;
      ARB: begin
        if (!halted && (req0 || req1)) begin
          grant_d     = (req0 && req1) ? !last_grant_q : req1;
          issue_cnt_d = '0;
          beat_cnt_d  = '0;
          state_d     = READ;
        end else if (!halted && !enable) begin
          state_d = IDLE;
        end
      end
      READ:  if (rd_en && (issue_cnt_q == CW'(FFT_LEN - 1))) state_d = DRAIN;
      DRAIN: if (pop && fft_tlast) state_d = DONE;
      DONE: begin
        if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
        last_grant_d = grant_q;
        state_d      = enable ? ARB : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_300m or posedge locrstn) begin
    if (locrstn) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      issue_cnt_q  <= '0;
      beat_cnt_q   <= '0;
      inflight_q   <= 1'b0;
      for (int i = 0; i < 4; i++) skid_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      frame_cnt_q  <= '0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      issue_cnt_q  <= issue_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      inflight_q   <= inflight_d;
      skid_q       <= skid_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      frame_cnt_q  <= frame_cnt_d;
      underrun_q   <= underrun_d;
    end
  end

`ifdef FFT_SCHED_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == READ) && issue_left && (g_empty || !fft_tready) && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk_300m or posedge locrstn) begin
    if (locrstn) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fft_frame_sched: randomized bench checking frames against a
// frame-level round-robin reference model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fft_frame_sched;
  localparam int FFT_LEN = 512;
  localparam int DATA_W  = 48;
  localparam int CNT_W   = 13;
  localparam int BUDGET  = 20000;

  logic              clk_300m = 1'b0;
  logic              locrstn = 1'b1;
  logic              enable = 1'b0;
  logic [CNT_W-1:0]  src0_count = '0, src1_count = '0;
  logic              src0_empty = 1'b1, src1_empty = 1'b1;
  logic              src0_valid = 1'b0, src1_valid = 1'b0;
  logic [DATA_W-1:0] src0_dout = '0, src1_dout = '0;
  logic              fft_tready = 1'b1;
  logic              src0_rd_en, src1_rd_en, fft_tvalid, fft_tlast, fft_tuser;
  logic              frame_done, busy, underrun_err;
  logic [DATA_W-1:0] fft_tdata;
  logic [15:0]       frame_cnt, stall_cycles;

  // second instance for the frame-limit scenario
  logic              mf_en = 1'b0, mf_v0 = 1'b0, mf_v1 = 1'b0, mf_p0 = 1'b0, mf_p1 = 1'b0;
  logic [DATA_W-1:0] mf_d0 = '0, mf_d1 = '0, mf_tdata;
  logic              mf_rd0, mf_rd1, mf_tvalid, mf_tlast, mf_tuser, mf_done, mf_busy, mf_under;
  logic [15:0]       mf_fcnt, mf_stall;
  int                mf_done_n = 0, mf_late_rd = 0;

  always #2 clk_300m = ~clk_300m;

  fft_frame_sched dut (
    .clk_300m(clk_300m), .locrstn(locrstn), .enable(enable),
    .src0_count(src0_count), .src0_empty(src0_empty), .src0_rd_en(src0_rd_en),
    .src0_dout(src0_dout), .src0_valid(src0_valid),
    .src1_count(src1_count), .src1_empty(src1_empty), .src1_rd_en(src1_rd_en),
    .src1_dout(src1_dout), .src1_valid(src1_valid),
    .fft_tready(fft_tready), .fft_tdata(fft_tdata), .fft_tvalid(fft_tvalid),
    .fft_tlast(fft_tlast), .fft_tuser(fft_tuser), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .busy(busy), .underrun_err(underrun_err),
    .stall_cycles(stall_cycles)
  );

  fft_frame_sched #(.MAX_FRAMES(2)) u_dut_mf (
    .clk_300m(clk_300m), .locrstn(locrstn), .enable(mf_en),
    .src0_count(13'd1200), .src0_empty(1'b0), .src0_rd_en(mf_rd0),
    .src0_dout(mf_d0), .src0_valid(mf_v0),
    .src1_count(13'd1200), .src1_empty(1'b0), .src1_rd_en(mf_rd1),
    .src1_dout(mf_d1), .src1_valid(mf_v1),
    .fft_tready(1'b1), .fft_tdata(mf_tdata), .fft_tvalid(mf_tvalid),
    .fft_tlast(mf_tlast), .fft_tuser(mf_tuser), .frame_done(mf_done),
    .frame_cnt(mf_fcnt), .busy(mf_busy), .underrun_err(mf_under),
    .stall_cycles(mf_stall)
  );

  // FIFO models, back-pressure source and monitor
  logic [DATA_W-1:0] q0[$], q1[$];
  logic              pend0 = 1'b0, pend1 = 1'b0;
  logic [DATA_W-1:0] pdata0 = '0, pdata1 = '0;
  int                tready_mode = 0, tog = 0, cyc = 0;
  logic [DATA_W-1:0] out_data[$], exp_data[$];
  bit                out_user[$], exp_user[$];
  int                last_idx[$], last_cyc[$], done_cyc[$];
  int                tb_occ = 0, max_occ = 0, tv_bad = 0, empty_reads = 0;
  int                first_rd_cyc = -1, first_tv_cyc = -1;
  bit                model_last = 1'b1;
  int                asserts = 0, fails = 0;

  always @(posedge clk_300m) begin
    #1;
    src0_valid = pend0;
    if (pend0) src0_dout = pdata0;
    src1_valid = pend1;
    if (pend1) src1_dout = pdata1;
    src0_empty = (q0.size() == 0);
    src1_empty = (q1.size() == 0);
    case (tready_mode)
      1: begin tog = (tog + 1) % 6; fft_tready = (tog < 3); end
      2: fft_tready = ($urandom_range(0, 3) != 0);
      default: fft_tready = 1'b1;
    endcase
    mf_v0 = mf_p0;
    mf_v1 = mf_p1;
    mf_d0 = DATA_W'($urandom());
    mf_d1 = DATA_W'($urandom());
  end

  always @(negedge clk_300m) begin
    cyc++;
    mf_p0 = mf_rd0;
    mf_p1 = mf_rd1;
    pend0 = 1'b0;
    pend1 = 1'b0;
    if (locrstn) begin
      tb_occ = 0;
    end else begin
      if (mf_done) mf_done_n++;
      else if (mf_done_n >= 2 && (mf_rd0 || mf_rd1)) mf_late_rd++;
      if (src0_rd_en) begin
        if (q0.size() == 0) empty_reads++;
        else begin pdata0 = q0.pop_front(); pend0 = 1'b1; end
      end
      if (src1_rd_en) begin
        if (q1.size() == 0) empty_reads++;
        else begin pdata1 = q1.pop_front(); pend1 = 1'b1; end
      end
      if ((src0_rd_en || src1_rd_en) && first_rd_cyc < 0) first_rd_cyc = cyc;
      if (fft_tvalid && first_tv_cyc < 0) first_tv_cyc = cyc;
      if (fft_tvalid !== (tb_occ != 0)) tv_bad++;
      if (fft_tvalid && fft_tready) begin
        out_data.push_back(fft_tdata);
        out_user.push_back(fft_tuser);
        if (fft_tlast) begin last_idx.push_back(out_data.size() - 1); last_cyc.push_back(cyc); end
      end
      if (frame_done) done_cyc.push_back(cyc);
      tb_occ = tb_occ + ((fft_tuser ? src1_valid : src0_valid) ? 1 : 0)
                      - ((fft_tvalid && fft_tready) ? 1 : 0);
      if (tb_occ > max_occ) max_occ = tb_occ;
    end
  end

  function automatic bit model_grant(bit r0, bit r1, bit last);
    if (r0 && r1) return !last;
    return r1;
  endfunction

  task automatic model_frames(input int n, input bit r0, input bit r1);
    logic [DATA_W-1:0] s0[$], s1[$];
    bit g;
    s0 = q0;
    s1 = q1;
    exp_data.delete();
    exp_user.delete();
    for (int f = 0; f < n; f++) begin
      g = model_grant(r0, r1, model_last);
      for (int i = 0; i < FFT_LEN; i++) begin
        exp_data.push_back(g ? s1.pop_front() : s0.pop_front());
        exp_user.push_back(g);
      end
      model_last = g;
    end
  endtask

  // Counts every deviation of the captured stream from the expected one.
  function automatic int frame_errors(int n);
    int e = 0;
    if (out_data.size() != exp_data.size()) e++;
    for (int i = 0; i < out_data.size() && i < exp_data.size(); i++)
      if (out_data[i] !== exp_data[i] || out_user[i] !== exp_user[i]) e++;
    if (last_idx.size() != n || done_cyc.size() != n || last_cyc.size() != n) e++;
    for (int i = 0; i < last_idx.size(); i++) if (last_idx[i] != i * FFT_LEN + FFT_LEN - 1) e++;
    for (int i = 0; i < done_cyc.size() && i < last_cyc.size(); i++)
      if (done_cyc[i] != last_cyc[i] + 1) e++;
    if (max_occ > 4 || tv_bad != 0 || empty_reads != 0) e++;
    return e;
  endfunction

  task automatic clear_mon();
    out_data.delete(); out_user.delete(); last_idx.delete(); last_cyc.delete(); done_cyc.delete();
    max_occ = 0; tv_bad = 0; empty_reads = 0; first_rd_cyc = -1; first_tv_cyc = -1;
  endtask

  task automatic apply_reset();
    @(negedge clk_300m);
    #1 locrstn = 1'b1;
    enable = 1'b0;
    tready_mode = 0;
    q0.delete();
    q1.delete();
    repeat (3) @(negedge clk_300m);
    clear_mon();
    model_last = 1'b1;
    #1 locrstn = 1'b0;
  endtask

  task automatic fill(input bit s, input int n);
    for (int i = 0; i < n; i++) begin
      if (s) q1.push_back(DATA_W'({$urandom(), $urandom()}));
      else   q0.push_back(DATA_W'({$urandom(), $urandom()}));
    end
  endtask

  task automatic run_frames(input int n, output bit ok);
    int k = 0;
    enable = 1'b1;
    while (done_cyc.size() < n - 1 && k < BUDGET) begin @(negedge clk_300m); k++; end
    while (!(src0_rd_en || src1_rd_en) && k < BUDGET) begin @(negedge clk_300m); k++; end
    #1 enable = 1'b0;
    while (done_cyc.size() < n && k < BUDGET) begin @(negedge clk_300m); k++; end
    ok = (k < BUDGET);
    repeat (3) @(negedge clk_300m);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_300m);
    asserts++;
    if ({src0_rd_en, src1_rd_en, fft_tvalid, fft_tlast, fft_tuser, frame_done, busy, underrun_err} !== 8'h00) begin
      fails++; $display("FAIL reset_flags: got %b expected 00000000",
        {src0_rd_en, src1_rd_en, fft_tvalid, fft_tlast, fft_tuser, frame_done, busy, underrun_err});
    end
    asserts++;
    if ({fft_tdata, frame_cnt, stall_cycles} !== '0) begin
      fails++; $display("FAIL reset_words: tdata=%h frame_cnt=%0d stall=%0d expected all 0", fft_tdata, frame_cnt, stall_cycles);
    end
    #1 locrstn = 1'b0;
  endtask

  task automatic test_single_source();
    bit ok;
    int e;
    apply_reset();
    fill(1'b0, 600);
    src0_count = 13'd1200; src1_count = 13'd0;
    model_frames(1, 1'b1, 1'b0);
    run_frames(1, ok);
    e = frame_errors(1);
    asserts++; if (!ok) begin fails++; $display("FAIL single_timeout: frame_done not seen within %0d cycles", BUDGET); end
    asserts++; if (out_data.size() != FFT_LEN) begin fails++; $display("FAIL single_beats: got %0d expected %0d", out_data.size(), FFT_LEN); end
    asserts++; if (e != 0) begin fails++; $display("FAIL single_stream: %0d errors, expected 0", e); end
    asserts++; if (frame_cnt !== 16'd1) begin fails++; $display("FAIL single_frame_cnt: got %0d expected 1", frame_cnt); end
    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle: busy=%b expected 0", busy); end
    asserts++; if (first_tv_cyc - first_rd_cyc != 2) begin fails++; $display("FAIL single_latency: got %0d expected 2", first_tv_cyc - first_rd_cyc); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int e, bad_g;
    apply_reset();
    fill(1'b0, 1100); fill(1'b1, 1100);
    src0_count = 13'd1200; src1_count = 13'd1200;
    model_frames(4, 1'b1, 1'b1);
    run_frames(4, ok);
    e = frame_errors(4);
    bad_g = 0;
    for (int f = 0; f < 4; f++)
      if (out_data.size() <= f * FFT_LEN || out_user[f * FFT_LEN] !== f[0]) bad_g++;
    asserts++; if (!ok) begin fails++; $display("FAIL rr_timeout: 4 frames not done within %0d cycles", BUDGET); end
    asserts++; if (bad_g != 0) begin fails++; $display("FAIL rr_grants: %0d wrong grants, expected order 0,1,0,1", bad_g); end
    asserts++; if (e != 0) begin fails++; $display("FAIL rr_stream: %0d errors, expected 0", e); end
    asserts++; if (frame_cnt !== 16'd4) begin fails++; $display("FAIL rr_frame_cnt: got %0d expected 4", frame_cnt); end
    asserts++; if (first_tv_cyc - first_rd_cyc != 2) begin fails++; $display("FAIL rr_latency: got %0d expected 2", first_tv_cyc - first_rd_cyc); end
  endtask

  task automatic test_tready_toggle();
    bit ok;
    int seq_bad;
    apply_reset();
    for (int i = 0; i < 600; i++) q0.push_back(DATA_W'(i));
    src0_count = 13'd1200; src1_count = 13'd0;
    model_frames(1, 1'b1, 1'b0);
    tready_mode = 1;
    run_frames(1, ok);
    seq_bad = (out_data.size() != FFT_LEN) ? 1 : 0;
    for (int i = 0; i < out_data.size(); i++) if (out_data[i] !== DATA_W'(i)) seq_bad++;
    asserts++; if (!ok) begin fails++; $display("FAIL toggle_timeout: frame_done not seen within %0d cycles", BUDGET); end
    asserts++; if (seq_bad != 0) begin fails++; $display("FAIL toggle_sequence: %0d beats out of order, expected 0 (got %0d beats)", seq_bad, out_data.size()); end
    asserts++; if (max_occ > 4 || tv_bad != 0) begin fails++; $display("FAIL toggle_occupancy: max occ %0d tvalid errors %0d, expected <=4 and 0", max_occ, tv_bad); end
    asserts++; if (frame_errors(1) != 0) begin fails++; $display("FAIL toggle_stream: %0d errors, expected 0", frame_errors(1)); end
  endtask

  task automatic test_random_backpressure();
    bit ok;
    apply_reset();
    fill(1'b1, 520 + $urandom_range(0, 100));
    src0_count = 13'd0; src1_count = 13'd1100 + 13'($urandom_range(0, 500));
    model_frames(1, 1'b0, 1'b1);
    tready_mode = 2;
    run_frames(1, ok);
    asserts++; if (!ok) begin fails++; $display("FAIL random_timeout: frame_done not seen within %0d cycles", BUDGET); end
    asserts++; if (frame_errors(1) != 0) begin fails++; $display("FAIL random_stream: %0d errors, expected 0", frame_errors(1)); end
  endtask

  task automatic test_underrun();
    logic [DATA_W-1:0] stash[$];
    int k = 0;
    apply_reset();
    fill(1'b0, 600);
    src0_count = 13'd1200; src1_count = 13'd0;
    model_frames(1, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) stash.push_back(q0.pop_back());
    enable = 1'b1;
    while (!src0_rd_en && k < BUDGET) begin @(negedge clk_300m); k++; end
    #1 enable = 1'b0;
    while (q0.size() != 0 && k < BUDGET) begin @(negedge clk_300m); k++; end
    repeat (50) @(negedge clk_300m);
    while (stash.size() != 0) q0.push_back(stash.pop_back());
    while (done_cyc.size() < 1 && k < BUDGET) begin @(negedge clk_300m); k++; end
    repeat (3) @(negedge clk_300m);
    asserts++; if (k >= BUDGET) begin fails++; $display("FAIL underrun_timeout: frame not done within %0d cycles", BUDGET); end
    asserts++; if (underrun_err !== 1'b1) begin fails++; $display("FAIL underrun_flag: got %b expected 1", underrun_err); end
    asserts++; if (frame_errors(1) != 0) begin fails++; $display("FAIL underrun_stream: %0d errors, expected 0", frame_errors(1)); end
`ifdef FFT_SCHED_STALL_CNT_EN
    asserts++; if (stall_cycles < 16'd50) begin fails++; $display("FAIL underrun_stall: got %0d expected >= 50", stall_cycles); end
`else
    asserts++; if (stall_cycles !== 16'd0) begin fails++; $display("FAIL underrun_stall: got %0d expected 0", stall_cycles); end
`endif
  endtask

  task automatic test_max_frames();
    apply_reset();
    mf_done_n = 0;
    mf_late_rd = 0;
    mf_en = 1'b1;
    repeat (2000) @(negedge clk_300m);
    asserts++; if (mf_done_n != 2) begin fails++; $display("FAIL maxf_pulses: got %0d expected 2", mf_done_n); end
    asserts++; if (mf_fcnt !== 16'd2) begin fails++; $display("FAIL maxf_frame_cnt: got %0d expected 2", mf_fcnt); end
    asserts++;
    if (mf_busy !== 1'b1 || mf_rd0 !== 1'b0 || mf_rd1 !== 1'b0 || mf_late_rd != 0) begin
      fails++; $display("FAIL maxf_hold: busy=%b rd=%b%b late reads=%0d expected busy=1 rd=00 late=0", mf_busy, mf_rd1, mf_rd0, mf_late_rd);
    end
    mf_en = 1'b0;
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int k = 0;
    apply_reset();
    fill(1'b0, 1200); fill(1'b1, 1200);
    src0_count = 13'd1200; src1_count = 13'd1200;
    enable = 1'b1;
    while (out_data.size() < 200 && k < BUDGET) begin @(negedge clk_300m); k++; end
    asserts++; if (last_idx.size() != 0) begin fails++; $display("FAIL midrst_early_tlast: got %0d tlast beats expected 0", last_idx.size()); end
    #1 locrstn = 1'b1;
    #1;
    asserts++;
    if ({src0_rd_en, src1_rd_en, fft_tvalid, fft_tlast, fft_tuser, frame_done, busy, underrun_err, fft_tdata, frame_cnt} !== '0) begin
      fails++; $display("FAIL midrst_outputs: valid=%b busy=%b rd=%b%b tdata=%h expected all 0", fft_tvalid, busy, src1_rd_en, src0_rd_en, fft_tdata);
    end
    repeat (3) @(negedge clk_300m);
    clear_mon();
    model_last = 1'b1;
    model_frames(1, 1'b1, 1'b1);
    #1 locrstn = 1'b0;
    run_frames(1, ok);
    asserts++; if (!ok || k >= BUDGET) begin fails++; $display("FAIL midrst_timeout: frame not completed within %0d cycles", BUDGET); end
    asserts++; if (out_user.size() == 0 || out_user[0] !== 1'b0) begin fails++; $display("FAIL midrst_grant: first frame not from source 0 (beats %0d)", out_user.size()); end
    asserts++; if (frame_errors(1) != 0) begin fails++; $display("FAIL midrst_stream: %0d errors, expected 0", frame_errors(1)); end
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_round_robin();
    test_tready_toggle();
    test_random_backpressure();
    test_underrun();
    test_max_frames();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
`default_nettype wire
